// File: rtl/dm_arbiter.sv
// Two-port data-memory arbiter: round-robin between load/store unit (port 0) and DMA/debug (port 1).
// Latency: request sampled in IDLE -> gnt next cycle; rvalid MEM_LAT+2 cycles after sample (2 if rejected).
// Backpressure: a port holds req and fields until its gnt; requests seen outside IDLE simply wait.
//
// Ports:
//   clk, rst                  clock, asynchronous active-low reset
//   pN_req/we/width/addr/wdata request from port N (width 00 byte, 01 half, 10 word, 11 illegal)
//   pN_gnt                    one-cycle accept pulse (fields captured)
//   pN_rvalid, pN_err         one-cycle completion pulse, err qualifies a rejected access
//   rdata                     shared response data, held between responses
//   mem_re/we/width/addr/wdata/rdata  data-memory side; mem_width is 11 whenever no strobe is active
//
// Timing of a legal access (sample in IDLE at cycle s):
//   s+1            ISSUE, gnt, first strobe cycle, counter loaded with MEM_LAT-1
//   s+2..s+MEM_LAT WAIT with counter non-zero, strobes continue
//   s+MEM_LAT+1    WAIT with counter at zero: strobes low, the read data registered on the
//                  last strobe cycle is moved to the response register
//   s+MEM_LAT+2    RESP
// A rejected access goes ISSUE -> RESP with no strobes at all.
module dm_arbiter #(
    parameter int MEM_LAT = 1
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        p0_req,
    input  logic        p0_we,
    input  logic [1:0]  p0_width,
    input  logic [31:0] p0_addr,
    input  logic [31:0] p0_wdata,
    input  logic        p1_req,
    input  logic        p1_we,
    input  logic [1:0]  p1_width,
    input  logic [31:0] p1_addr,
    input  logic [31:0] p1_wdata,
    output logic        p0_gnt,
    output logic        p1_gnt,
    output logic        p0_rvalid,
    output logic        p1_rvalid,
    output logic        p0_err,
    output logic        p1_err,
    output logic [31:0] rdata,
    output logic        mem_re,
    output logic        mem_we,
    output logic [1:0]  mem_width,
    output logic [31:0] mem_addr,
    output logic [31:0] mem_wdata,
    input  logic [31:0] mem_rdata
);

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        ISSUE = 2'd1,
        WAIT  = 2'd2,
        RESP  = 2'd3
    } state_t;

    localparam logic [2:0] CNT_INIT = 3'(MEM_LAT - 1);
    // With a single-cycle memory the ISSUE cycle is also the last strobe cycle.
    localparam logic       LAT_ONE  = (MEM_LAT == 1);

    state_t      r_state;
    state_t      w_state_nxt;

    logic        r_last;      // port granted most recently (1 after reset so port 0 wins the first tie)
    logic        r_port;      // port owning the current access
    logic        r_we;
    logic        r_err;       // captured access is illegal
    logic [1:0]  r_width;
    logic [2:0]  r_cnt;
    logic [31:0] r_addr;
    logic [31:0] r_wdata;
    logic [31:0] r_rbuf;      // masked read data taken on the last strobe cycle
    logic [31:0] r_rdata;

    logic        w_any_req;
    logic        w_win;
    logic        w_sel_we;
    logic        w_sel_err;
    logic [1:0]  w_sel_width;
    logic [31:0] w_sel_addr;
    logic [31:0] w_sel_wdata;
    logic [31:0] w_rd_masked;
    logic        w_strobe;
    logic        w_last_strobe;

    // ------------------------------------------------------------------
    // Arbitration and request selection
    // ------------------------------------------------------------------
    assign w_any_req = p0_req | p1_req;

    // Tie goes to the port not granted last; otherwise the sole requester wins.
    assign w_win = (p0_req & p1_req) ? ~r_last : p1_req;

    assign w_sel_we    = w_win ? p1_we    : p0_we;
    assign w_sel_width = w_win ? p1_width : p0_width;
    assign w_sel_addr  = w_win ? p1_addr  : p0_addr;
    assign w_sel_wdata = w_win ? p1_wdata : p0_wdata;

    // Illegal width code, or a half/word access that is not naturally aligned.
    assign w_sel_err = (w_sel_width == 2'b11)
                     | ((w_sel_width == 2'b01) & w_sel_addr[0])
                     | ((w_sel_width == 2'b10) & (w_sel_addr[1:0] != 2'b00));

    // Read data is zero-extended from the low lanes according to the captured width.
    always_comb begin
        w_rd_masked = mem_rdata;
        case (r_width)
            2'b00:   w_rd_masked = {24'h0, mem_rdata[7:0]};
            2'b01:   w_rd_masked = {16'h0, mem_rdata[15:0]};
            default: w_rd_masked = mem_rdata;
        endcase
    end

    // ------------------------------------------------------------------
    // FSM: state register
    // ------------------------------------------------------------------
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_state <= IDLE;
        end else begin
            r_state <= w_state_nxt;
        end
    end

    // ------------------------------------------------------------------
    // FSM: next state and handshake outputs
    // ------------------------------------------------------------------
    always_comb begin
        w_state_nxt   = r_state;
        w_strobe      = 1'b0;
        w_last_strobe = 1'b0;
        p0_gnt        = 1'b0;
        p1_gnt        = 1'b0;
        p0_rvalid     = 1'b0;
        p1_rvalid     = 1'b0;
        case (r_state)
            IDLE: begin
                if (w_any_req) begin
                    w_state_nxt = ISSUE;
                end
            end
            ISSUE: begin
                p0_gnt = ~r_port;
                p1_gnt = r_port;
                if (r_err) begin
                    w_state_nxt = RESP;
                end else begin
                    w_strobe      = 1'b1;
                    w_last_strobe = LAT_ONE;
                    w_state_nxt   = WAIT;
                end
            end
            WAIT: begin
                // Non-zero count: strobe cycles remain. Zero: turnaround before the response.
                if (r_cnt != 3'd0) begin
                    w_strobe      = 1'b1;
                    w_last_strobe = (r_cnt == 3'd1);
                end else begin
                    w_state_nxt = RESP;
                end
            end
            RESP: begin
                p0_rvalid   = ~r_port;
                p1_rvalid   = r_port;
                w_state_nxt = IDLE;
            end
            default: begin
                w_state_nxt = IDLE;
            end
        endcase
    end

    assign p0_err    = p0_rvalid & r_err;
    assign p1_err    = p1_rvalid & r_err;
    assign mem_re    = w_strobe & ~r_we;
    assign mem_we    = w_strobe & r_we;
    assign mem_width = w_strobe ? r_width : 2'b11;
    assign mem_addr  = r_addr;
    assign mem_wdata = r_wdata;
    assign rdata     = r_rdata;

    // ------------------------------------------------------------------
    // Capture, pointer, counter and response data
    // ------------------------------------------------------------------
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_last  <= 1'b1;
            r_port  <= 1'b0;
            r_we    <= 1'b0;
            r_err   <= 1'b0;
            r_width <= 2'b11;
            r_cnt   <= 3'd0;
            r_addr  <= 32'h0;
            r_wdata <= 32'h0;
            r_rbuf  <= 32'h0;
            r_rdata <= 32'h0;
        end else begin
            if ((r_state == IDLE) && w_any_req) begin
                r_port  <= w_win;
                r_we    <= w_sel_we;
                r_err   <= w_sel_err;
                r_width <= w_sel_width;
                r_addr  <= w_sel_addr;
                r_wdata <= w_sel_wdata;
            end

            // Pointer moves on every grant, rejected accesses included.
            if (r_state == ISSUE) begin
                r_last <= r_port;
                r_cnt  <= CNT_INIT;
            end else if ((r_state == WAIT) && (r_cnt != 3'd0)) begin
                r_cnt <= r_cnt - 3'd1;
            end

            if (w_last_strobe && !r_we) begin
                r_rbuf <= w_rd_masked;
            end

            // rdata changes only on entry to RESP and holds otherwise.
            if (w_state_nxt == RESP) begin
                r_rdata <= (!r_err && !r_we) ? r_rbuf : 32'h0;
            end
        end
    end

endmodule

// File: tb/tb_dm_arbiter.sv
module tb_dm_arbiter;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    int errors = 0;
    int checks = 0;
    bit done [2];

    task automatic chk(input int lane, input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL lane%0d %s: got %08h expected %08h", lane, name, act, exp);
        end
    endtask

    function automatic bit legal_acc(input logic [1:0] w, input logic [31:0] a);
        return !((w == 2'b11) || ((w == 2'b01) && a[0]) || ((w == 2'b10) && (a[1:0] != 2'b00)));
    endfunction

    function automatic logic [31:0] mask_rd(input logic [1:0] w, input logic [31:0] d);
        case (w)
            2'b00:   return d & 32'h0000_00FF;
            2'b01:   return d & 32'h0000_FFFF;
            default: return d;
        endcase
    endfunction

    // Lane 0 runs a single-cycle memory, lane 1 a three-cycle memory.
    for (genvar g = 0; g < 2; g++) begin : lane
        localparam int LAT = (g == 0) ? 1 : 3;

        logic        rst = 1'b1;
        logic        req   [2];
        logic        we    [2];
        logic [1:0]  wid   [2];
        logic [31:0] addr  [2];
        logic [31:0] wdata [2];
        logic [31:0] mem_rdata = 32'h0;
        logic        gnt0, gnt1, rv0, rv1, err0, err1, mem_re, mem_we;
        logic [1:0]  mem_width;
        logic [31:0] mem_addr, mem_wdata, rdata;

        dm_arbiter #(.MEM_LAT(LAT)) u_dut (
            .clk       (clk),
            .rst       (rst),
            .p0_req    (req[0]),
            .p0_we     (we[0]),
            .p0_width  (wid[0]),
            .p0_addr   (addr[0]),
            .p0_wdata  (wdata[0]),
            .p1_req    (req[1]),
            .p1_we     (we[1]),
            .p1_width  (wid[1]),
            .p1_addr   (addr[1]),
            .p1_wdata  (wdata[1]),
            .p0_gnt    (gnt0),
            .p1_gnt    (gnt1),
            .p0_rvalid (rv0),
            .p1_rvalid (rv1),
            .p0_err    (err0),
            .p1_err    (err1),
            .rdata     (rdata),
            .mem_re    (mem_re),
            .mem_we    (mem_we),
            .mem_width (mem_width),
            .mem_addr  (mem_addr),
            .mem_wdata (mem_wdata),
            .mem_rdata (mem_rdata)
        );

        // Reference model: one outstanding transaction described by its sample cycle
        // and fields; every expected output is a function of the cycle number.
        int          m_cyc = 0;
        int          idle_from = 0;
        bit          t_act = 0;
        int          t_s, t_resp;
        bit          t_port, t_we, t_legal;
        logic [1:0]  t_wid;
        logic [31:0] t_addr, t_wdata;
        bit          last = 1;
        logic [31:0] e_addr = 0, e_wdata = 0, e_rdata = 0, rbuf = 0;
        bit          m_gnt [2];

        always @(negedge clk) begin : model
            logic       g0, g1, rv, strb;
            logic [7:0] e_ctrl;
            logic [1:0] e_wid;
            int         win;
            if (!rst) begin
                t_act = 0; last = 1; e_addr = 0; e_wdata = 0; e_rdata = 0;
                idle_from = m_cyc + 1;
                g0 = 0; g1 = 0; rv = 0; strb = 0;
            end else begin
                g0   = t_act && (m_cyc == t_s + 1) && !t_port;
                g1   = t_act && (m_cyc == t_s + 1) && t_port;
                rv   = t_act && (m_cyc == t_resp);
                strb = t_act && t_legal && (m_cyc >= t_s + 1) && (m_cyc <= t_s + LAT);
                if (t_act && (m_cyc == t_s + 1)) begin
                    e_addr = t_addr; e_wdata = t_wdata;
                end
                if (strb && !t_we && (m_cyc == t_s + LAT)) rbuf = mask_rd(t_wid, mem_rdata);
                if (rv) e_rdata = (t_legal && !t_we) ? rbuf : 32'h0;
            end
            e_ctrl = {g0, g1, rv && !t_port, rv && t_port, rv && !t_legal && !t_port,
                      rv && !t_legal && t_port, strb && !t_we, strb && t_we};
            e_wid  = strb ? t_wid : 2'b11;
            m_gnt[0] = g0;
            m_gnt[1] = g1;
            chk(g, "ctrl", 32'({gnt0, gnt1, rv0, rv1, err0, err1, mem_re, mem_we}), 32'(e_ctrl));
            chk(g, "mem_width", 32'(mem_width), 32'(e_wid));
            chk(g, "mem_addr", mem_addr, e_addr);
            chk(g, "mem_wdata", mem_wdata, e_wdata);
            chk(g, "rdata", rdata, e_rdata);
            if (rv) t_act = 0;
            if (rst && !t_act && (m_cyc >= idle_from) && (req[0] || req[1])) begin
                win     = (req[0] && req[1]) ? int'(!last) : int'(req[1]);
                t_act   = 1;
                t_s     = m_cyc;
                t_port  = (win == 1);
                t_we    = we[win];
                t_wid   = wid[win];
                t_addr  = addr[win];
                t_wdata = wdata[win];
                t_legal = legal_acc(t_wid, t_addr);
                t_resp  = t_legal ? t_s + LAT + 2 : t_s + 2;
                idle_from = t_resp + 1;
                last    = t_port;
            end
            m_cyc++;
        end

        task automatic reset_check(input string tag);
            chk(g, {tag, "_ctrl"}, 32'({gnt0, gnt1, rv0, rv1, err0, err1, mem_re, mem_we}), 32'h0);
            chk(g, {tag, "_width"}, 32'(mem_width), 32'h3);
            chk(g, {tag, "_addr"}, mem_addr, 32'h0);
            chk(g, {tag, "_wdata"}, mem_wdata, 32'h0);
            chk(g, {tag, "_rdata"}, rdata, 32'h0);
        endtask

        // Both ports request continuously from a fresh reset: grants must alternate from port 0.
        task automatic alternate();
            int seen [$];
            int budget;
            @(posedge clk); #1;
            for (int p = 0; p < 2; p++) begin
                req[p] = 1; we[p] = 0; wid[p] = 2'b10; addr[p] = 32'h100 * (p + 1); wdata[p] = 0;
            end
            budget = 0;
            while (seen.size() < 4 && budget < 60) begin
                @(negedge clk);
                budget++;
                if (gnt0 && !gnt1) seen.push_back(0);
                else if (gnt1 && !gnt0) seen.push_back(1);
            end
            @(posedge clk); #1;
            req[0] = 0; req[1] = 0;
            chk(g, "alt_count", 32'(seen.size()), 32'd4);
            for (int i = 0; i < seen.size(); i++) chk(g, "alt_order", 32'(seen[i]), 32'(i % 2));
            repeat (LAT + 4) @(posedge clk);
        endtask

        // One access from an idle arbiter, checked cycle by cycle against literal expectations.
        task automatic do_access(input int p, input bit w_en, input logic [1:0] w, input logic [31:0] a,
                                 input logic [31:0] d, input logic [31:0] rd, input bit x_err,
                                 input logic [31:0] x_rdata);
            int lat_exp;
            bit strb;
            lat_exp = x_err ? 2 : LAT + 2;
            @(posedge clk); #1;
            mem_rdata = rd;
            req[p] = 1; we[p] = w_en; wid[p] = w; addr[p] = a; wdata[p] = d;
            for (int c = 0; c <= LAT + 4; c++) begin
                @(negedge clk);
                strb = !x_err && (c >= 1) && (c <= LAT);
                chk(g, "acc_gnt", 32'({gnt1, gnt0}), (c == 1) ? ((p == 0) ? 32'h1 : 32'h2) : 32'h0);
                chk(g, "acc_strobe", 32'({mem_re, mem_we}), strb ? (w_en ? 32'h1 : 32'h2) : 32'h0);
                chk(g, "acc_width", 32'(mem_width), strb ? 32'(w) : 32'h3);
                chk(g, "acc_rvalid", 32'({rv1, rv0}), (c == lat_exp) ? ((p == 0) ? 32'h1 : 32'h2) : 32'h0);
                if (c >= 1) begin
                    chk(g, "acc_addr", mem_addr, a);
                    chk(g, "acc_wdata", mem_wdata, d);
                end
                if (c == lat_exp) chk(g, "acc_err", 32'({err1, err0}), x_err ? ((p == 0) ? 32'h1 : 32'h2) : 32'h0);
                if (c == lat_exp || c == lat_exp + 1) chk(g, "acc_rdata", rdata, x_rdata);
                if (c == 1) begin
                    @(posedge clk); #1;
                    req[p] = 0;
                end
            end
        endtask

        // Reset during WAIT: everything returns to reset values at once, the held request is re-granted.
        task automatic mid_reset();
            @(posedge clk); #1;
            mem_rdata = 32'h55AA_55AA;
            req[0] = 1; we[0] = 0; wid[0] = 2'b10; addr[0] = 32'h2000; wdata[0] = 0;
            @(posedge clk);
            @(posedge clk); #1;
            rst = 0;
            #1;
            reset_check("mid");
            repeat (2) begin
                @(negedge clk);
                chk(g, "abort_rvalid", 32'({rv1, rv0}), 32'h0);
            end
            @(posedge clk); #1;
            rst = 1;
            @(negedge clk);
            chk(g, "regnt_early", 32'(gnt0), 32'h0);
            @(negedge clk);
            chk(g, "regnt", 32'(gnt0), 32'h1);
            @(posedge clk); #1;
            req[0] = 0;
            repeat (LAT + 4) @(posedge clk);
        endtask

        initial begin : drv
            for (int p = 0; p < 2; p++) begin
                req[p] = 0; we[p] = 0; wid[p] = 0; addr[p] = 0; wdata[p] = 0;
            end
            #2 rst = 0;
            #1 reset_check("por");
            repeat (2) @(posedge clk);
            #1 rst = 1;

            alternate();
            do_access(1, 0, 2'b00, 32'h1002, 32'h0, 32'hFFEE_DDCC, 0, 32'h0000_00CC);
            do_access(1, 0, 2'b01, 32'h1002, 32'h0, 32'hFFEE_DDCC, 0, 32'h0000_DDCC);
            do_access(1, 1, 2'b10, 32'h1008, 32'h1234_5678, 32'hDEAD_BEEF, 0, 32'h0);
            do_access(0, 0, 2'b10, 32'h1004, 32'h0, 32'hA1B2_C3D4, 0, 32'hA1B2_C3D4);
            do_access(0, 1, 2'b10, 32'h1002, 32'hCAFE_F00D, 32'h0, 1, 32'h0);
            do_access(0, 0, 2'b00, 32'h1010, 32'h0, 32'h8877_6655, 0, 32'h0000_0055);
            do_access(0, 1, 2'b11, 32'h1002, 32'hCAFE_F00D, 32'h0, 1, 32'h0);
            mid_reset();

            repeat (3000) begin
                @(posedge clk); #1;
                mem_rdata = $urandom;
                rst = ($urandom_range(0, 499) != 0);
                for (int p = 0; p < 2; p++) begin
                    if (m_gnt[p]) req[p] = 0;
                    if (!req[p] && ($urandom_range(0, 2) == 0)) begin
                        req[p]   = 1;
                        we[p]    = 1'($urandom_range(0, 1));
                        wid[p]   = 2'($urandom_range(0, 3));
                        addr[p]  = $urandom;
                        wdata[p] = $urandom;
                        if ($urandom_range(0, 9) < 7) begin
                            if (wid[p] == 2'b01) addr[p][0] = 1'b0;
                            if (wid[p] == 2'b10) addr[p][1:0] = 2'b00;
                        end
                    end
                end
            end
            @(posedge clk); #1;
            rst = 1; req[0] = 0; req[1] = 0;
            repeat (LAT + 6) @(posedge clk);
            done[g] = 1;
        end
    end

    initial begin : summary
        int t;
        t = 0;
        while (!(done[0] && done[1]) && t < 60000) begin
            @(posedge clk);
            t++;
        end
        if (!(done[0] && done[1])) begin
            checks++;
            errors++;
            $display("FAIL timeout: lanes done=%0d%0d expected 11", done[0], done[1]);
        end
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
